// File: rtl/spisbox.sv
// SPI slave (CPOL=1) with a 64-bit TX mailbox and a 64-bit RX mailbox.
// All SPI pins are resynchronised into clk; the FSM state and MISO enable are exposed for debug.
module spisbox (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       cs,
    output logic       ready,
    input  logic [2:0] windex,
    input  logic [7:0] wdata,
    input  logic       wstrb,
    input  logic [2:0] rindex,
    output logic [7:0] rdata,
    output logic       valid,
    output logic [1:0] dbg_state,
    output logic       dbg_miso_oe
);

    // Handshake: ready means "a complete TX mailbox is queued and no frame is active";
    // valid means "the RX mailbox holds a complete 64-bit frame", held until the next cs fall.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  sclk_s_q;
    logic [2:0]  cs_s_q;
    logic [1:0]  mosi_s_q;
    logic        wstrb_q;
    logic [6:0]  bit_cnt_q;
    logic [7:0]  tx_mbox_q [8];
    logic [7:0]  rx_mbox_q [8];
    logic [63:0] tx_shift_q;
    logic [63:0] rx_shift_q;
    logic        update_q;
    logic        valid_q;
    logic [7:0]  rdata_q;
    logic        oe_q;

    logic        sclk_rise, sclk_fall, cs_fall, cs_rise, wr_commit, bit_full;
    logic [63:0] tx_word;

    assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
    assign sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];
    assign cs_fall   = ~cs_s_q[1] & cs_s_q[2];
    assign cs_rise   = cs_s_q[1] & ~cs_s_q[2];
    assign wr_commit = wstrb_q & ~wstrb;
    assign bit_full  = (bit_cnt_q == 7'd64);
    assign tx_word   = {tx_mbox_q[0], tx_mbox_q[1], tx_mbox_q[2], tx_mbox_q[3],
                        tx_mbox_q[4], tx_mbox_q[5], tx_mbox_q[6], tx_mbox_q[7]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = bit_full ? DONE : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // cs sync resets low so a cs held low through reset cannot look like a fall.
            sclk_s_q   <= 3'b111;
            cs_s_q     <= 3'b000;
            mosi_s_q   <= 2'b00;
            wstrb_q    <= 1'b0;
            bit_cnt_q  <= 7'd0;
            tx_shift_q <= 64'd0;
            rx_shift_q <= 64'd0;
            update_q   <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= 8'd0;
            oe_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                tx_mbox_q[i] <= 8'd0;
                rx_mbox_q[i] <= 8'd0;
            end
        end else begin
            sclk_s_q <= {sclk_s_q[1:0], sclk};
            cs_s_q   <= {cs_s_q[1:0], cs};
            mosi_s_q <= {mosi_s_q[0], mosi};
            wstrb_q  <= wstrb;

            if (wr_commit) tx_mbox_q[windex] <= wdata;

            if (state_q == IDLE && cs_fall) begin
                tx_shift_q <= tx_word;
                bit_cnt_q  <= 7'd0;
                valid_q    <= 1'b0;
                update_q   <= 1'b0;
                oe_q       <= 1'b1;
            end else begin
                if (wr_commit && windex == 3'd7) update_q <= 1'b1;
                if (cs_s_q[1]) oe_q <= 1'b0;
                // The first fall of a frame (bit_cnt==0) leaves bit 63 on the line.
                if (state_q == ACTIVE && !bit_full) begin
                    if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[62:0], mosi_s_q[1]};
                        bit_cnt_q  <= bit_cnt_q + 7'd1;
                    end else if (sclk_fall && bit_cnt_q != 7'd0) begin
                        tx_shift_q <= {tx_shift_q[62:0], 1'b0};
                    end
                end
                if (state_q == DONE) begin
                    for (int i = 0; i < 8; i++) begin
                        rx_mbox_q[i] <= rx_shift_q[63 - 8*i -: 8];
                    end
                    valid_q <= 1'b1;
                end
            end

            if (valid_q) rdata_q <= rx_mbox_q[rindex];
        end
    end

    assign dbg_miso_oe = oe_q & ~cs_s_q[1];
    assign miso        = dbg_miso_oe ? tx_shift_q[63] : 1'bz;
    assign ready       = update_q & (state_q == IDLE);
    assign valid       = valid_q;
    assign rdata       = rdata_q;
    assign dbg_state   = state_q;

endmodule
